map_2_stream: RTL and testbench
===============================

# map_2_stream

Output-side serializer for the convolution datapath, the return path to the AXI input feed. It accepts parallel result vectors from the PE array (up to `lanes` results per load, each with its own valid bit) into a two-bank ping-pong buffer. It drains them one word per cycle onto a valid/ready stream toward AXI, counting output pixels per feature map. It flags the last pixel and pulses `map_finish` when a full `out_row`×`out_row` map has been sent.

## Interface
- `data_width`, 16, result word width
- `lanes`, 25, result words per load vector
- `out_row`, 24, output map side; map size `map_pixels = out_row*out_row` (576)
- `clk`  in  1  single clock, all logic on rising edge
- `nrst`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle pulse, begins a new map
- `load`  in  1  load request for one result vector
- `res_vld`  in  `lanes`  per-lane valid mask of `res_in`
- `res_in`  in  `lanes` × `data_width` (unpacked array `[lanes-1:0]`)  result vector
- `load_rdy`  out  1  a bank is free and a map is running
- `m_data`  out  `data_width`  stream data
- `m_valid`  out  1  stream valid
- `m_ready`  in  1  stream ready from AXI side
- `m_last`  out  1  marks pixel `map_pixels-1` of the map
- `map_finish`  out  1  one-cycle pulse after the last pixel transfers

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: `start` → RUN; pixel counter cleared; banks cleared.
  - RUN: load and drain active.
  - DONE: one cycle, `map_finish`=1 → IDLE.
  - `start` outside IDLE is ignored.
- Banks: two, each holding `lanes` words plus a `lanes`-bit mask.
  - Load pointer and drain pointer each toggle between banks; banks are drained in load order.
  - `load_rdy` = RUN and the load-pointer bank is empty.
  - Accept = `load && load_rdy`: capture `res_in`/`res_vld` into that bank, mark it full, toggle the load pointer.
  - `load` while `!load_rdy` is ignored; no data is captured.
- Drain: the full bank at the drain pointer emits words in ascending lane index and skips lanes whose mask bit is 0.
  - The next set bit is found by priority encoder over the remaining mask.
  - A bank with all-zero mask is freed without emitting any beat.
  - A bank is freed on the cycle its last set lane transfers. It is free for loading on the next cycle, and the drain pointer toggles.
- Stream rules:
  - A transfer occurs when `m_valid && m_ready`.
  - While `m_valid && !m_ready`, `m_data`/`m_last` hold stable and `m_valid` stays high.
  - `m_valid` never drops without a transfer, except on reset.
- Pixel counter: `$clog2(map_pixels)` bits, +1 per transfer.
  - `m_last` = `m_valid` and counter == `map_pixels-1`.
  - On the `m_last` transfer, go to DONE. Remaining bank contents are discarded, and banks, pointers and counter are cleared.
  - No beat is emitted in DONE or IDLE.
- Simultaneous events:
  - Load into one bank while the other drains is allowed.
  - A bank freed and loaded in the same cycle is not allowed, because `load_rdy` is registered from the previous cycle's bank state.

## Timing
- Reset (`nrst`=0 at an edge): `m_valid`=0, `m_data`=0, `m_last`=0, `map_finish`=0, `load_rdy`=0, state IDLE, banks empty, pointers 0, counter 0.
  - Reset mid-map drops any in-flight beat and all buffered data.
- `load_rdy` rises the cycle after `start` is sampled.
- Load accepted at edge N: the first beat of that bank has `m_valid`=1 after edge N+1, provided the drain path is idle.
- Throughput: 1 word/cycle with `m_ready` held high, including across a bank boundary when the next bank is already full. No bubble between set lanes.
- `map_finish`: high exactly one cycle, in the cycle after the `m_last` transfer edge. `load_rdy`=0 from that cycle until the next `start`.
- Output registers: `m_data`, `m_valid`, `m_last`, `map_finish`, `load_rdy`.

## Test plan
- Reset then `start`. Load `res_in[i]=i+1`, `res_vld`=all ones, `m_ready`=1 → 25 beats of data 1..25 on consecutive cycles, first beat 1 cycle after the load edge. `m_last`=0 throughout.
- Mask `res_vld=25'h0000015` (lanes 0, 2, 4) → exactly 3 beats, data `res_in[0]`, `res_in[2]`, `res_in[4]`. All-zero mask → no beats, and the bank is freed.
- Stall: hold `m_ready`=0 for 5 cycles mid-bank → `m_data` stable and `m_valid`=1 throughout. The sequence resumes with no loss or duplication.
- Ping-pong: two back-to-back loads, then a third → third load is refused (`load_rdy`=0) until bank A drains. The 50 beats arrive with no gap at the A→B boundary.
- Full map: stream 576 valid words (23 full loads + 1 with 1 lane set) → `m_last` on beat 576 only, then `map_finish` a 1-cycle pulse, state IDLE. A later `load` is ignored.
- Assert `nrst`=0 mid-bank with `m_valid`=1 → all outputs 0 at the next edge. After `start`, the first beat comes from the new load only.

Source files
------------

// File: rtl/map_2_stream.sv
// Result serializer: PE-array result vectors are captured into a two-bank ping-pong
// buffer and drained one masked lane per cycle onto a valid/ready stream, one map at a time.
module map_2_stream #(
   parameter int data_width = 16,
   parameter int lanes      = 25,
   parameter int out_row    = 24
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  start,
   input  logic                  load,
   input  logic [lanes-1:0]      res_vld,
   input  logic [data_width-1:0] res_in [lanes-1:0],
   output logic                  load_rdy,
   output logic [data_width-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last,
   output logic                  map_finish
);

   localparam int map_pixels = out_row * out_row;
   localparam int cnt_w      = $clog2(map_pixels);
   localparam logic [cnt_w-1:0] last_pix = cnt_w'(map_pixels - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_q, state_d;
   logic [1:0]            bank_full_q, bank_full_d;
   logic [lanes-1:0]      bank_mask_q [2];
   logic [lanes-1:0]      bank_mask_d [2];
   logic [data_width-1:0] bank_data_q [2][lanes];
   logic [data_width-1:0] bank_data_d [2][lanes];
   logic                  ld_ptr_q, ld_ptr_d;
   logic                  dr_ptr_q, dr_ptr_d;
   logic [cnt_w-1:0]      cnt_q, cnt_d;
   logic [data_width-1:0] m_data_q, m_data_d;
   logic                  m_valid_q, m_valid_d;
   logic                  m_last_q, m_last_d;
   logic                  map_finish_q, map_finish_d;
   logic                  load_rdy_q, load_rdy_d;
   logic                  out_bank_q, out_bank_d;
   logic                  out_free_q, out_free_d;

   logic [lanes-1:0]      cur_mask;
   logic [lanes-1:0]      rem_mask;
   logic [data_width-1:0] sel_data;
   logic                  xfer;
   logic                  pending;

   // Lowest remaining set lane of the bank under the drain pointer.
   always_comb begin
      cur_mask = bank_mask_q[dr_ptr_q];
      rem_mask = cur_mask & (cur_mask - 1'b1);
      sel_data = '0;
      for (int i = lanes - 1; i >= 0; i--) begin
         if (cur_mask[i]) begin
            sel_data = bank_data_q[dr_ptr_q][i];
         end
      end
   end

   assign xfer    = m_valid_q && m_ready;
   // The drain bank's final beat may still sit in the output register after a
   // zero-mask bank swung the pointer back; that bank is released by its transfer.
   assign pending = m_valid_q && out_free_q && (out_bank_q == dr_ptr_q);

   always_comb begin
      state_d     = state_q;
      bank_full_d = bank_full_q;
      bank_mask_d = bank_mask_q;
      bank_data_d = bank_data_q;
      ld_ptr_d    = ld_ptr_q;
      dr_ptr_d    = dr_ptr_q;
      cnt_d       = cnt_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;
      out_bank_d  = out_bank_q;
      out_free_d  = out_free_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d        = RUN;
               bank_full_d    = '0;
               bank_mask_d[0] = '0;
               bank_mask_d[1] = '0;
               ld_ptr_d       = 1'b0;
               dr_ptr_d       = 1'b0;
               cnt_d          = '0;
            end
         end
         RUN: begin
            if (load && load_rdy_q) begin
               bank_full_d[ld_ptr_q] = 1'b1;
               bank_mask_d[ld_ptr_q] = res_vld;
               for (int i = 0; i < lanes; i++) begin
                  bank_data_d[ld_ptr_q][i] = res_in[i];
               end
               ld_ptr_d = ~ld_ptr_q;
            end

            if (xfer) begin
               cnt_d     = cnt_q + 1'b1;
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               if (out_free_q) begin
                  bank_full_d[out_bank_q] = 1'b0;
               end
            end

            if (bank_full_q[dr_ptr_q] && (cur_mask != '0)) begin
               if (!m_valid_q || m_ready) begin
                  m_valid_d             = 1'b1;
                  m_data_d              = sel_data;
                  m_last_d              = (cnt_d == last_pix);
                  out_bank_d            = dr_ptr_q;
                  out_free_d            = (rem_mask == '0);
                  bank_mask_d[dr_ptr_q] = rem_mask;
                  if (rem_mask == '0) begin
                     dr_ptr_d = ~dr_ptr_q;
                  end
               end
            end else if (bank_full_q[dr_ptr_q] && !pending) begin
               bank_full_d[dr_ptr_q] = 1'b0;
               dr_ptr_d              = ~dr_ptr_q;
            end

            // Final pixel of the map: drop whatever is still buffered.
            if (xfer && m_last_q) begin
               state_d        = DONE;
               bank_full_d    = '0;
               bank_mask_d[0] = '0;
               bank_mask_d[1] = '0;
               ld_ptr_d       = 1'b0;
               dr_ptr_d       = 1'b0;
               cnt_d          = '0;
               m_valid_d      = 1'b0;
               m_last_d       = 1'b0;
               m_data_d       = '0;
               out_bank_d     = 1'b0;
               out_free_d     = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      map_finish_d = (state_d == DONE);
      load_rdy_d   = (state_d == RUN) && !bank_full_d[ld_ptr_d];
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q        <= IDLE;
         bank_full_q    <= '0;
         bank_mask_q[0] <= '0;
         bank_mask_q[1] <= '0;
         ld_ptr_q       <= 1'b0;
         dr_ptr_q       <= 1'b0;
         cnt_q          <= '0;
         m_data_q       <= '0;
         m_valid_q      <= 1'b0;
         m_last_q       <= 1'b0;
         map_finish_q   <= 1'b0;
         load_rdy_q     <= 1'b0;
         out_bank_q     <= 1'b0;
         out_free_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         bank_full_q    <= bank_full_d;
         bank_mask_q[0] <= bank_mask_d[0];
         bank_mask_q[1] <= bank_mask_d[1];
         ld_ptr_q       <= ld_ptr_d;
         dr_ptr_q       <= dr_ptr_d;
         cnt_q          <= cnt_d;
         m_data_q       <= m_data_d;
         m_valid_q      <= m_valid_d;
         m_last_q       <= m_last_d;
         map_finish_q   <= map_finish_d;
         load_rdy_q     <= load_rdy_d;
         out_bank_q     <= out_bank_d;
         out_free_q     <= out_free_d;
      end
   end

   // Payload words need no reset: an empty bank's mask gates them out.
   always_ff @(posedge clk) begin
      bank_data_q <= bank_data_d;
   end

   assign load_rdy   = load_rdy_q;
   assign m_data     = m_data_q;
   assign m_valid    = m_valid_q;
   assign m_last     = m_last_q;
   assign map_finish = map_finish_q;

endmodule

// File: tb/tb_map_2_stream.sv
// Self-checking bench for map_2_stream: vector table plus hand sequences, with a
// scoreboard queue of expected beats checked by a stream monitor.
module tb_map_2_stream;

   localparam int DW    = 16;
   localparam int LANES = 25;
   localparam int PIX   = 576;

   logic          clk = 1'b0;
   logic          nrst;
   logic          start;
   logic          load;
   logic [LANES-1:0] res_vld;
   logic [DW-1:0] res_in [LANES-1:0];
   logic          load_rdy;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_last;
   logic          map_finish;

   map_2_stream #(.data_width(DW), .lanes(LANES), .out_row(24)) dut (
      .clk(clk), .nrst(nrst), .start(start), .load(load), .res_vld(res_vld),
      .res_in(res_in), .load_rdy(load_rdy), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_last(m_last), .map_finish(map_finish)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   typedef struct {
      logic [LANES-1:0] mask;
      int               base;
      int               exp_beats;
   } vec_t;

   beat_t sb[$];
   int errors = 0;
   int checks = 0;
   int beats = 0;
   int last_count = 0;
   int fin_count = 0;
   int cyc = 0;
   int last_xfer_cyc = -10;
   int exp_pix = 0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic          prev_last = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stream monitor: scoreboard compare, stall stability, finish-pulse timing.
   always @(negedge clk) begin
      if (!nrst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", int'(m_valid), 1);
            chk("stall_data", int'(m_data), int'(prev_data));
            chk("stall_last", int'(m_last), int'(prev_last));
         end
         if (m_valid && m_ready) begin
            beats++;
            if (m_last) begin
               last_count++;
               last_xfer_cyc = cyc;
            end
            if (sb.size() == 0) begin
               chk("unexpected_beat", int'(m_data), -1);
            end else begin
               beat_t e;
               e = sb.pop_front();
               $display("beat %0d data=%0d last=%0b exp_data=%0d exp_last=%0b",
                        beats, m_data, m_last, e.d, e.l);
               chk("beat_data", int'(m_data), int'(e.d));
               chk("beat_last", int'(m_last), int'(e.l));
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_last  = m_last;
         if (map_finish) begin
            fin_count++;
            chk("finish_timing", cyc, last_xfer_cyc + 1);
         end
      end
   end

   task automatic set_vec(input logic [LANES-1:0] mask, input int base);
      for (int i = 0; i < LANES; i++) res_in[i] = DW'(base + i);
      res_vld = mask;
   endtask

   task automatic push_vec(input logic [LANES-1:0] mask, input int base);
      for (int i = 0; i < LANES; i++) begin
         if (mask[i]) begin
            beat_t e;
            e.d = DW'(base + i);
            e.l = (exp_pix == PIX - 1);
            sb.push_back(e);
            exp_pix++;
         end
      end
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (!load_rdy && n < 300) begin
         tick();
         n++;
      end
      if (!load_rdy) chk("load_rdy_timeout", 0, 1);
   endtask

   task automatic do_load(input logic [LANES-1:0] mask, input int base);
      wait_rdy();
      set_vec(mask, base);
      load = 1'b1;
      push_vec(mask, base);
      tick();
      load = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || m_valid) && n < 3000) begin
         tick();
         n++;
      end
      if (sb.size() != 0 || m_valid) chk("drain_timeout", sb.size(), 0);
      tick();
   endtask

   vec_t vecs[6];

   initial begin
      int b0;
      int acc_j;
      logic [DW-1:0] held;

      vecs[0] = '{mask: 25'h1FFFFFF, base: 100, exp_beats: 25};
      vecs[1] = '{mask: 25'h0000015, base: 200, exp_beats: 3};
      vecs[2] = '{mask: 25'h0000000, base: 300, exp_beats: 0};
      vecs[3] = '{mask: 25'h1000001, base: 400, exp_beats: 2};
      vecs[4] = '{mask: 25'h0F0F0F0, base: 500, exp_beats: 12};
      vecs[5] = '{mask: 25'h1000000, base: 560, exp_beats: 1};

      nrst = 1'b0; start = 1'b0; load = 1'b0; m_ready = 1'b1;
      set_vec('0, 0);
      repeat (3) tick();
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_m_data", int'(m_data), 0);
      chk("rst_m_last", int'(m_last), 0);
      chk("rst_map_finish", int'(map_finish), 0);
      chk("rst_load_rdy", int'(load_rdy), 0);

      nrst = 1'b1;
      tick();
      chk("idle_load_rdy", int'(load_rdy), 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_load_rdy", int'(load_rdy), 1);

      // First load: latency and back-to-back 25 beats.
      do_load(25'h1FFFFFF, 1);
      chk("lat_no_beat_yet", int'(m_valid), 0);
      tick();
      chk("lat_first_valid", int'(m_valid), 1);
      chk("lat_first_data", int'(m_data), 1);
      b0 = beats;
      repeat (25) tick();
      chk("burst_beats", beats - b0, 25);
      chk("burst_idle_after", int'(m_valid), 0);

      // Vector table: various masks, each drained before the next.
      foreach (vecs[k]) begin
         b0 = beats;
         do_load(vecs[k].mask, vecs[k].base);
         wait_drain();
         chk($sformatf("vec%0d_beats", k), beats - b0, vecs[k].exp_beats);
      end

      // Stall mid-bank.
      do_load(25'h1FFFFFF, 600);
      repeat (4) tick();
      m_ready = 1'b0;
      held = m_data;
      repeat (5) begin
         tick();
         chk("stall_hold_valid", int'(m_valid), 1);
         chk("stall_hold_data", int'(m_data), int'(held));
      end
      m_ready = 1'b1;
      wait_drain();

      // Ping-pong: two back-to-back loads, third refused until bank A frees.
      wait_rdy();
      set_vec(25'h1FFFFFF, 700);
      load = 1'b1;
      push_vec(25'h1FFFFFF, 700);
      tick();
      chk("pp_rdy_second", int'(load_rdy), 1);
      set_vec(25'h1FFFFFF, 800);
      push_vec(25'h1FFFFFF, 800);
      tick();
      set_vec(25'h1FFFFFF, 900);
      chk("pp_refused", int'(load_rdy), 0);
      b0 = beats;
      acc_j = -1;
      for (int j = 0; j < 75; j++) begin
         if (acc_j < 0 && load_rdy) begin
            acc_j = j;
            push_vec(25'h1FFFFFF, 900);
         end
         tick();
         if (acc_j == j) load = 1'b0;
      end
      load = 1'b0;
      chk("pp_accept_cycle", acc_j, 25);
      chk("pp_beats_no_gap", beats - b0, 75);
      chk("pp_idle_after", int'(m_valid), 0);

      // Reset in the middle of a bank.
      do_load(25'h1FFFFFF, 1000);
      repeat (3) tick();
      chk("midrst_pre_valid", int'(m_valid), 1);
      nrst = 1'b0;
      tick();
      chk("midrst_m_valid", int'(m_valid), 0);
      chk("midrst_m_data", int'(m_data), 0);
      chk("midrst_m_last", int'(m_last), 0);
      chk("midrst_load_rdy", int'(load_rdy), 0);
      chk("midrst_finish", int'(map_finish), 0);
      sb.delete();
      exp_pix = 0;
      nrst = 1'b1;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;

      // Full map: 23 full loads plus one single-lane load.
      b0 = beats;
      last_count = 0;
      fin_count = 0;
      for (int k = 0; k < 23; k++) begin
         do_load(25'h1FFFFFF, 2000 + 25 * k);
         if (k == 0) begin
            tick();
            chk("post_rst_first_data", int'(m_data), 2000);
         end
      end
      do_load(25'h0000008, 3000);
      wait_drain();
      repeat (3) tick();
      chk("map_beats", beats - b0, PIX);
      chk("map_last_count", last_count, 1);
      chk("map_finish_count", fin_count, 1);
      chk("map_done_load_rdy", int'(load_rdy), 0);

      // Load after finish is ignored.
      b0 = beats;
      set_vec(25'h1FFFFFF, 4000);
      load = 1'b1;
      repeat (5) tick();
      load = 1'b0;
      chk("post_map_beats", beats - b0, 0);
      chk("post_map_valid", int'(m_valid), 0);
      chk("post_map_load_rdy", int'(load_rdy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
